// File: rtl/iomem_pwm.sv
// PWM slave on the picosoc iomem bus. It owns one shared period counter and NCH duty channels.
// Duty and period updates go through shadow registers, so they only take effect when the counter wraps.

module iomem_pwm_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wval,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] duty,
  output logic             pwm
);
  logic [CNT_W-1:0] duty_sh;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty    <= '0;
      duty_sh <= '0;
      pwm     <= 1'b0;
    end else begin
      if (wr_en) duty <= wval;
      if (load)  duty_sh <= duty;
      pwm <= enable && (count < duty_sh);
    end
  end
endmodule

module iomem_pwm #(
  parameter int         NCH       = 8,
  parameter int         CNT_W     = 16,
  parameter logic [7:0] BASE_PAGE = 8'h04
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           iomem_valid,
  output logic           iomem_ready,
  input  logic [3:0]     iomem_wstrb,
  input  logic [31:0]    iomem_addr,
  input  logic [31:0]    iomem_wdata,
  output logic [31:0]    iomem_rdata,
  output logic [NCH-1:0] pwm_out,
  output logic           period_irq
);
  function automatic logic [CNT_W-1:0] merge_bytes(input logic [CNT_W-1:0] old,
                                                   input logic [31:0] wd,
                                                   input logic [3:0] st);
    logic [CNT_W-1:0] r;
    r = old;
    for (int b = 0; b < CNT_W; b++) if (st[b/8]) r[b] = wd[b];
    return r;
  endfunction

  logic       sel, wr, wr_ctrl, wr_period;
  logic [5:0] off;
  logic       enable, irq_en, irq_pend;
  logic       wrap, load;
  logic [CNT_W-1:0] period, period_sh, count;
  logic [NCH-1:0][CNT_W-1:0] duty_all, duty_wv;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};
  assign off       = iomem_addr[7:2];
  assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_PAGE);
  assign wr        = sel && (iomem_wstrb != 4'b0000);
  assign wr_ctrl   = wr && (off == 6'd0);
  assign wr_period = wr && (off == 6'd1);

  // Disabled: shadows track the live registers every cycle, so enabling starts from fresh values.
  assign wrap = enable && (count == period_sh);
  assign load = wrap || !enable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      irq_pend  <= 1'b0;
      period    <= '0;
      period_sh <= '0;
      count     <= '0;
    end else begin
      if (wr_ctrl && iomem_wstrb[0]) begin
        enable <= iomem_wdata[0];
        irq_en <= iomem_wdata[1];
      end
      // A wrap in the same cycle as a clear keeps the pending bit set.
      if (wrap) irq_pend <= 1'b1;
      else if (wr_ctrl && iomem_wstrb[1] && iomem_wdata[8]) irq_pend <= 1'b0;
      if (wr_period) period <= merge_bytes(period, iomem_wdata, iomem_wstrb);
      if (load) period_sh <= period;
      if (!enable || wrap) count <= '0;
      else                 count <= count + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign duty_wv[g] = merge_bytes(duty_all[g], iomem_wdata, iomem_wstrb);
    iomem_pwm_ch #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .wr_en  (wr && (off == 6'(4 + g))),
      .wval   (duty_wv[g]),
      .load   (load),
      .enable (enable),
      .count  (count),
      .duty   (duty_all[g]),
      .pwm    (pwm_out[g])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (off == 6'd0)      rd_mux = {23'b0, irq_pend, 6'b0, irq_en, enable};
    else if (off == 6'd1) rd_mux = 32'(period);
    else if (off == 6'd2) rd_mux = 32'(count);
    for (int i = 0; i < NCH; i++)
      if (off == 6'(4 + i)) rd_mux = 32'(duty_all[i]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      period_irq  <= 1'b0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= sel ? rd_mux : '0;
      period_irq  <= irq_pend & irq_en;
    end
  end
endmodule

// File: tb/tb_iomem_pwm.sv
// Bench for iomem_pwm: register-access vector table, directed PWM/IRQ sequences and randomized
// period/duty runs checked against a period-arithmetic model.
module tb_iomem_pwm;
  localparam int NCH = 8;
  localparam int CNT_W = 16;
  localparam logic [31:0] A_CTRL = 32'h0400_0000, A_PER = 32'h0400_0004,
                          A_CNT = 32'h0400_0008, A_DUTY = 32'h0400_0010;

  logic clk = 1'b0, resetn = 1'b1, iomem_valid = 1'b0, iomem_ready, period_irq;
  logic [3:0] iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0, iomem_wdata = 32'h0, iomem_rdata;
  logic [NCH-1:0] pwm_out;
  int total = 0, bad = 0, k = 0;

  iomem_pwm #(.NCH(NCH), .CNT_W(CNT_W), .BASE_PAGE(8'h04)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .pwm_out(pwm_out), .period_irq(period_irq));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          exp_ack;
    logic [31:0] exp_rd;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", nm, act, exp, k);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  // Called at a negedge; an acked access consumes exactly one negedge.
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output bit acked);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = wd; iomem_wstrb = st;
    acked = 1'b0; rd = 32'h0;
    for (int c = 0; c < 4 && !acked; c++) begin
      tick();
      if (iomem_ready) begin acked = 1'b1; rd = iomem_rdata; end
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r; bit ack;
    bus(a, wd, 4'hf, r, ack);
    chk("wr_ack", 32'(ack), 32'd1);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] r; bit ack;
    bus(a, 32'h0, 4'h0, r, ack);
    chk({nm, "_ack"}, 32'(ack), 32'd1);
    chk(nm, r, exp);
  endtask

  task automatic configure(input int p, input int d[NCH], input bit ie);
    wr(A_CTRL, {30'b0, ie, 1'b0});
    wr(A_CTRL, 32'h100 | {30'b0, ie, 1'b0});
    wr(A_PER, 32'(p));
    for (int i = 0; i < NCH; i++) wr(A_DUTY + 32'(4 * i), 32'(d[i]));
    wr(A_CTRL, {30'b0, ie, 1'b1});
    k = -1;
  endtask

  // Model: k-th sample after enable sees phase k mod (P+1); pend first lands on phase P.
  task automatic check_run(input int p, input int d[NCH], input bit ie, input int n, input string nm);
    logic [NCH-1:0] e;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int i = 0; i < NCH; i++) e[i] = ((k % (p + 1)) < d[i]);
      chk({nm, "_pwm"}, 32'(pwm_out), 32'(e));
      chk({nm, "_irq"}, 32'(period_irq), 32'(ie && (k >= p + 1)));
    end
    rd(A_CNT, 32'((k + 1) % (p + 1)), {nm, "_count"});
  endtask

  initial begin
    int d[NCH];
    logic [31:0] r;
    bit ack;
    logic [3:0] rp;

    #1 resetn = 1'b0;
    #2;
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_irq", 32'(period_irq), 32'h0);
    chk("rst_ready", 32'(iomem_ready), 32'h0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    tick();

    tbl.push_back('{A_PER,          32'h5,         4'hf, 1'b1, 32'h0,    "wr_period"});
    tbl.push_back('{A_PER,          32'h0,         4'h0, 1'b1, 32'h5,    "rd_period"});
    tbl.push_back('{32'h0400_0040,  32'h0,         4'h0, 1'b1, 32'h0,    "rd_unmapped"});
    tbl.push_back('{32'h0300_0004,  32'h0,         4'h0, 1'b0, 32'h0,    "rd_otherpage"});
    tbl.push_back('{A_PER,          32'hFFFF_FFFF, 4'hf, 1'b1, 32'h0,    "wr_period_ff"});
    tbl.push_back('{A_PER,          32'h0,         4'h0, 1'b1, 32'hFFFF, "rd_period_width"});
    tbl.push_back('{A_PER,          32'h1234_56AB, 4'h1, 1'b1, 32'h0,    "wr_period_b0"});
    tbl.push_back('{A_PER,          32'h0,         4'h0, 1'b1, 32'hFFAB, "rd_period_b0"});
    tbl.push_back('{A_DUTY,         32'h1234,      4'hf, 1'b1, 32'h0,    "wr_duty0"});
    tbl.push_back('{A_DUTY,         32'h0,         4'h0, 1'b1, 32'h1234, "rd_duty0"});
    tbl.push_back('{A_DUTY + 32'h1C, 32'hABCDEF,   4'hf, 1'b1, 32'h0,    "wr_duty7"});
    tbl.push_back('{A_DUTY + 32'h1C, 32'h0,        4'h0, 1'b1, 32'hCDEF, "rd_duty7"});
    tbl.push_back('{A_DUTY + 32'h20, 32'h55,       4'hf, 1'b1, 32'h0,    "wr_duty8"});
    tbl.push_back('{A_DUTY + 32'h20, 32'h0,        4'h0, 1'b1, 32'h0,    "rd_duty8"});
    tbl.push_back('{A_CNT,          32'h77,        4'hf, 1'b1, 32'h0,    "wr_count"});
    tbl.push_back('{A_CNT,          32'h0,         4'h0, 1'b1, 32'h0,    "rd_count"});
    tbl.push_back('{A_CTRL,         32'hFFFF_FE02, 4'h1, 1'b1, 32'h0,    "wr_ctrl"});
    tbl.push_back('{A_CTRL,         32'hFFFF_FF01, 4'h2, 1'b1, 32'h0,    "wr_ctrl_b1"});
    tbl.push_back('{A_CTRL,         32'h0,         4'h0, 1'b1, 32'h2,    "rd_ctrl"});
    tbl.push_back('{32'h0300_0000,  32'h1,         4'hf, 1'b0, 32'h0,    "wr_otherpage"});
    tbl.push_back('{A_CTRL,         32'h0,         4'h0, 1'b1, 32'h2,    "rd_ctrl2"});

    foreach (tbl[j]) begin
      bus(tbl[j].addr, tbl[j].wdata, tbl[j].wstrb, r, ack);
      chk({tbl[j].nm, "_ack"}, 32'(ack), 32'(tbl[j].exp_ack));
      if (ack && tbl[j].wstrb == 4'h0) chk(tbl[j].nm, r, tbl[j].exp_rd);
      if (ack) begin
        tick();
        chk({tbl[j].nm, "_ready1"}, 32'(iomem_ready), 32'h0);
      end
    end

    // Held request: acked every other cycle.
    iomem_valid = 1'b1; iomem_addr = A_PER; iomem_wstrb = 4'h0;
    for (int c = 0; c < 4; c++) begin tick(); rp[c] = iomem_ready; end
    iomem_valid = 1'b0;
    tick();
    chk("b2b_ready", 32'(rp), 32'h5);

    // Ratio + glitch-free duty change (3 -> 7 mid-period).
    d = '{3, 0, 12, 0, 0, 0, 0, 0};
    configure(9, d, 1'b0);
    tick();
    while (k < 30) begin
      chk("glitch_pwm", 32'(pwm_out), 32'({1'b1, 1'b0, ((k % 10) < (k < 10 ? 3 : 7))}));
      if (k == 1) wr(A_DUTY, 32'd7);
      else tick();
    end

    // IRQ: clear on a non-wrap cycle drops it, clear on a wrap cycle does not.
    d = '{2, 0, 0, 0, 0, 0, 0, 0};
    configure(4, d, 1'b1);
    tick();
    while (k < 20) begin
      chk("irq_seq", 32'(period_irq), 32'((k >= 5) && (k != 8) && (k != 9)));
      if (k == 6 || k == 13) wr(A_CTRL, 32'h103);
      else tick();
    end

    // PERIOD=0: every cycle wraps.
    d = '{1, 0, 0, 0, 0, 0, 0, 0};
    configure(0, d, 1'b1);
    check_run(0, d, 1'b1, 8, "p0");
    wr(A_CTRL, 32'h103);
    tick();
    chk("p0_irq_after_clr", 32'(period_irq), 32'h1);
    rd(A_CTRL, 32'h103, "p0_ctrl");

    for (int t = 0; t < 6; t++) begin
      int p;
      bit ie;
      p = int'($urandom_range(0, 12));
      for (int i = 0; i < NCH; i++) begin
        d[i] = int'($urandom_range(0, p + 3));
        if ($urandom_range(0, 3) == 0) d[i] = 0;
      end
      ie = 1'($urandom_range(0, 1));
      configure(p, d, ie);
      check_run(p, d, ie, 2 * (p + 1) + 3, $sformatf("rnd%0d", t));
    end

    // Mid-count asynchronous reset.
    d = '{3, 0, 12, 0, 0, 0, 0, 0};
    configure(9, d, 1'b1);
    check_run(9, d, 1'b1, 13, "prerst");
    #2 resetn = 1'b0;
    #1;
    chk("midrst_pwm", 32'(pwm_out), 32'h0);
    chk("midrst_irq", 32'(period_irq), 32'h0);
    chk("midrst_ready", 32'(iomem_ready), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    rd(A_CNT, 32'h0, "postrst_count");
    rd(A_CTRL, 32'h0, "postrst_ctrl");
    rd(A_PER, 32'h0, "postrst_period");
    tick();
    chk("postrst_pwm", 32'(pwm_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
